// File: rtl/fir_mac_scheduler.sv
// fir_mac_scheduler: time-multiplexed FIR engine, one signed MAC shared over N_TAPS cycles per sample.
// Optional macro FIR_SAT_EN: saturate the output to DW bits instead of wrapping.
module fir_mac_scheduler #(
    parameter int unsigned N_TAPS = 63,
    parameter int unsigned DW     = 16,
    parameter int unsigned CW     = 16,
    parameter int unsigned ACC_W  = 38,
    parameter int unsigned SHIFT  = 0,
    parameter int unsigned AW     = 6
) (
    input  logic          clk,
    input  logic          rst_p,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    input  logic          flush,
    output logic [AW-1:0] coef_addr,
    input  logic [CW-1:0] coef_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data,
    output logic          busy
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MAC,
        ST_OUT
    } state_t;

    localparam int unsigned   PW       = DW + CW;
    localparam logic [AW-1:0] LAST_TAP = AW'(N_TAPS - 1);
    localparam logic [AW:0]   NT_EXT   = (AW + 1)'(N_TAPS);

    state_t                  state_q, state_d;
    logic [DW-1:0]           hist_q [N_TAPS];
    logic [DW-1:0]           hist_d [N_TAPS];
    logic [AW-1:0]           wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]           base_q, base_d;
    logic [AW-1:0]           tap_q, tap_d;
    logic                    drain_q, drain_d;
    logic signed [PW-1:0]    prod_q, prod_d;
    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic signed [ACC_W-1:0] acc_sum;
    logic [DW-1:0]           out_data_q, out_data_d;
    logic [DW-1:0]           f_acc;
    logic [AW-1:0]           rd_idx;

    // Circular history read: newest sample at base, older ones walk backwards with wrap.
    always_comb begin
        rd_idx = AW'({1'b0, base_q} + ((base_q >= tap_q) ? '0 : NT_EXT) - {1'b0, tap_q});
    end

    // The product is registered, so the accumulator trails the tap sequence by one cycle.
    always_comb begin
        acc_sum = acc_q + $signed({{(ACC_W - PW){prod_q[PW-1]}}, prod_q});
    end

`ifdef FIR_SAT_EN
    localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W - DW + 1){1'b0}}, {(DW - 1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W - DW + 1){1'b1}}, {(DW - 1){1'b0}}};
    logic signed [ACC_W-1:0] acc_shr;

    always_comb begin
        acc_shr = acc_sum >>> SHIFT;
        if (acc_shr > SAT_MAX) begin
            f_acc = {1'b0, {(DW - 1){1'b1}}};
        end else if (acc_shr < SAT_MIN) begin
            f_acc = {1'b1, {(DW - 1){1'b0}}};
        end else begin
            f_acc = acc_shr[DW-1:0];
        end
    end
`else
    always_comb begin
        f_acc = DW'(acc_sum >>> SHIFT);
    end
`endif

    always_comb begin
        state_d    = state_q;
        hist_d     = hist_q;
        wr_ptr_d   = wr_ptr_q;
        base_d     = base_q;
        tap_d      = tap_q;
        drain_d    = drain_q;
        prod_d     = prod_q;
        acc_d      = acc_q;
        out_data_d = out_data_q;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        busy       = 1'b0;
        coef_addr  = '0;

        case (state_q)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (flush) begin
                    for (int unsigned i = 0; i < N_TAPS; i++) begin
                        hist_d[i] = '0;
                    end
                    wr_ptr_d = '0;
                end else if (in_valid) begin
                    hist_d[wr_ptr_q] = in_data;
                    base_d           = wr_ptr_q;
                    acc_d            = '0;
                    prod_d           = '0;
                    tap_d            = '0;
                    drain_d          = 1'b0;
                    state_d          = ST_MAC;
                end
            end

            ST_MAC: begin
                busy      = 1'b1;
                coef_addr = tap_q;
                acc_d     = acc_sum;
                if (drain_q) begin
                    out_data_d = f_acc;
                    drain_d    = 1'b0;
                    state_d    = ST_OUT;
                end else begin
                    prod_d = $signed(hist_q[rd_idx]) * $signed(coef_data);
                    if (tap_q == LAST_TAP) begin
                        tap_d   = '0;
                        drain_d = 1'b1;
                    end else begin
                        tap_d = tap_q + AW'(1);
                    end
                end
            end

            ST_OUT: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready) begin
                    wr_ptr_d = (wr_ptr_q == LAST_TAP) ? '0 : wr_ptr_q + AW'(1);
                    state_d  = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst_p) begin
        if (rst_p) begin
            state_q <= ST_IDLE;
            for (int unsigned i = 0; i < N_TAPS; i++) begin
                hist_q[i] <= '0;
            end
            wr_ptr_q   <= '0;
            base_q     <= '0;
            tap_q      <= '0;
            drain_q    <= 1'b0;
            prod_q     <= '0;
            acc_q      <= '0;
            out_data_q <= '0;
        end else begin
            state_q    <= state_d;
            hist_q     <= hist_d;
            wr_ptr_q   <= wr_ptr_d;
            base_q     <= base_d;
            tap_q      <= tap_d;
            drain_q    <= drain_d;
            prod_q     <= prod_d;
            acc_q      <= acc_d;
            out_data_q <= out_data_d;
        end
    end

    assign out_data = out_data_q;

endmodule

// File: tb/tb_fir_mac_scheduler.sv
// Bench for fir_mac_scheduler: convolution model over the accepted sample list plus directed checks.
// Honours FIR_SAT_EN when the design is built with it.
module tb_fir_mac_scheduler;

    logic        clk = 1'b0;
    logic        rst_p;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_data;
    logic        flush;
    logic [5:0]  coef_addr;
    logic [15:0] coef_data;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic        busy;

    fir_mac_scheduler #(
        .N_TAPS(63), .DW(16), .CW(16), .ACC_W(38), .SHIFT(0), .AW(6)
    ) dut (
        .clk(clk), .rst_p(rst_p), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .flush(flush), .coef_addr(coef_addr), .coef_data(coef_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .busy(busy)
    );

    always #5 clk = ~clk;

    logic signed [15:0] rom [63];
    logic signed [15:0] hx[$];
    logic [15:0]        exp_q[$];
    logic [15:0]        got[$];
    int                 n_cmp = 0;
    int                 n_bad = 0;

`ifdef FIR_SAT_EN
    localparam logic [15:0] OVF_FIRST = 16'h7FFF;
    localparam logic [15:0] OVF_LAST  = 16'h7FFF;
`else
    localparam logic [15:0] OVF_FIRST = 16'h0001;
    localparam logic [15:0] OVF_LAST  = 16'h003F;
`endif

    always_comb begin
        coef_data = (coef_addr < 6'd63) ? rom[coef_addr] : '0;
    end

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // y[n] = sum_k c[k] * x[n-k], samples before the last flush/reset taken as zero.
    function automatic logic [15:0] model_y();
        longint s = 0;
        int     n = hx.size();
        for (int k = 0; k < 63; k++) begin
            if (k < n) s += longint'(rom[k]) * longint'(hx[n - 1 - k]);
        end
`ifdef FIR_SAT_EN
        if (s > 32767) return 16'h7FFF;
        if (s < -32768) return 16'h8000;
`endif
        return s[15:0];
    endfunction

    always @(negedge clk) begin
        if (rst_p) begin
            hx.delete();
            exp_q.delete();
        end else begin
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    check("spurious_out_valid", out_valid, 1'b0);
                end else begin
                    check("out_data", out_data, exp_q[0]);
                    if (out_ready) begin
                        got.push_back(out_data);
                        void'(exp_q.pop_front());
                    end
                end
            end
            if (in_ready) begin
                check("coef_addr_idle", coef_addr, 6'd0);
                if (flush) begin
                    hx.delete();
                end else if (in_valid) begin
                    hx.push_back(in_data);
                    if (hx.size() > 63) void'(hx.pop_front());
                    exp_q.push_back(model_y());
                end
            end
        end
    end

    task automatic send(input logic [15:0] x);
        int n = 0;
        in_valid = 1'b1;
        in_data  = x;
        @(negedge clk);
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("send_bound", (n < 200), 1'b1);
        @(posedge clk);
        #2;
        in_valid = 1'b0;
    endtask

    task automatic drain_wait();
        int n = 0;
        while ((exp_q.size() != 0 || !in_ready) && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("drain_bound", (n < 300), 1'b1);
        @(posedge clk);
        #2;
    endtask

    task automatic do_flush();
        flush = 1'b1;
        @(posedge clk);
        #2;
        flush = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int base;
        int lat_ov;
        int lat_ir;
        int ov_cnt;
        int n;
        logic signed [15:0] half [32] = '{
            -16'sd1, -16'sd1, -16'sd1, -16'sd2, -16'sd2, -16'sd2, -16'sd1, 16'sd0,
            16'sd1, 16'sd2, 16'sd3, 16'sd4, 16'sd4, 16'sd3, 16'sd1, -16'sd2,
            -16'sd5, -16'sd8, -16'sd10, -16'sd10, -16'sd7, -16'sd1, 16'sd8, 16'sd20,
            16'sd35, 16'sd52, 16'sd70, 16'sd88, 16'sd104, 16'sd116, 16'sd123, 16'sd125
        };
        for (int k = 0; k < 32; k++) begin
            rom[k]      = half[k];
            rom[62 - k] = half[k];
        end
        rst_p     = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        flush     = 1'b0;
        out_ready = 1'b1;

        #1;
        check("rst_in_ready", in_ready, 1'b1);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_out_data", out_data, 16'h0000);
        check("rst_coef_addr", coef_addr, 6'd0);
        check("rst_busy", busy, 1'b0);
        repeat (2) @(posedge clk);
        #2;
        rst_p = 1'b0;

        // Latency: accept at edge 0
        in_valid = 1'b1;
        in_data  = 16'd3;
        @(posedge clk);
        #2;
        in_valid = 1'b0;
        lat_ov = 0;
        lat_ir = 0;
        for (int k = 1; k <= 80; k++) begin
            @(posedge clk);
            #1;
            if (k == 1) check("busy_in_mac", busy, 1'b1);
            if (out_valid && lat_ov == 0) lat_ov = k;
            if (in_ready && lat_ir == 0) lat_ir = k;
        end
        #1;
        check("latency_out_valid", lat_ov, 64);
        check("latency_in_ready", lat_ir, 65);
        drain_wait();
        check("latency_value", got[0], 16'hFFFD);

        // Impulse response
        do_flush();
        base = got.size();
        send(16'd1);
        repeat (62) send(16'd0);
        drain_wait();
        check("impulse_count", got.size() - base, 63);
        check("impulse_0", got[base + 0], 16'hFFFF);
        check("impulse_3", got[base + 3], 16'hFFFE);
        check("impulse_7", got[base + 7], 16'h0000);
        check("impulse_8", got[base + 8], 16'h0001);
        check("impulse_31", got[base + 31], 16'h007D);
        check("impulse_62", got[base + 62], 16'hFFFF);

        // Backpressure
        out_ready = 1'b0;
        send(16'd5);
        n = 0;
        while (!out_valid && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("bp_wait_bound", (n < 200), 1'b1);
        @(posedge clk);
        #2;
        in_valid = 1'b1;
        in_data  = 16'h1234;
        repeat (20) begin
            @(posedge clk);
            #1;
            check("bp_out_valid", out_valid, 1'b1);
            check("bp_out_data", out_data, 16'hFFFB);
            check("bp_in_ready", in_ready, 1'b0);
            #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        drain_wait();

        // Flush behaviour
        base = got.size();
        send(16'd100);
        drain_wait();
        do_flush();
        send(16'd1);
        drain_wait();
        flush    = 1'b1;
        in_valid = 1'b1;
        in_data  = 16'd77;
        @(posedge clk);
        #1;
        check("flush_wins_in_ready", in_ready, 1'b1);
        check("flush_wins_busy", busy, 1'b0);
        #1;
        flush    = 1'b0;
        in_valid = 1'b0;
        send(16'd1);
        drain_wait();
        check("pre_flush", got[base + 0], 16'hFF97);
        check("post_flush", got[base + 1], 16'hFFFF);
        check("flush_drop", got[base + 2], 16'hFFFF);

        // Reset mid-MAC
        send(16'd9);
        repeat (30) @(posedge clk);
        #1;
        check("abort_coef_addr", coef_addr, 6'd30);
        check("abort_busy", busy, 1'b1);
        #1;
        rst_p = 1'b1;
        #1;
        check("abort_out_valid", out_valid, 1'b0);
        check("abort_out_data", out_data, 16'h0000);
        check("abort_in_ready", in_ready, 1'b1);
        check("abort_busy_low", busy, 1'b0);
        @(negedge clk);
        @(posedge clk);
        #2;
        rst_p  = 1'b0;
        ov_cnt = 0;
        repeat (80) begin
            @(negedge clk);
            if (out_valid) ov_cnt++;
        end
        check("abort_no_output", ov_cnt, 0);
        @(posedge clk);
        #2;

        // Overflow
        for (int k = 0; k < 63; k++) rom[k] = 16'sh7FFF;
        do_flush();
        base = got.size();
        repeat (63) send(16'h7FFF);
        drain_wait();
        check("ovf_count", got.size() - base, 63);
        check("ovf_first", got[base + 0], OVF_FIRST);
        check("ovf_last", got[base + 62], OVF_LAST);

        check("exp_queue_empty", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
